// File: rtl/kws_act_pkg.sv
// Shared types and constants for the ReLU activation collector.
package kws_act_pkg;

    localparam int ACT_DEPTH  = 32;
    localparam int ACT_ADDR_W = 5;
    localparam int ACT_DATA_W = 32;

    // 6.0 in Q1.7.24
    localparam logic [31:0] RELU6_MAX = 32'h0600_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } act_state_t;

endpackage

// File: rtl/act_regfile.sv
// Activation store: one synchronous write port, one asynchronous read port, no reset.
module act_regfile #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/relu_result_collector.sv
// Collects ReLU output beats into a register file and drains a full frame in address order.
// Optional RELU6_CLIP_EN clips stored values above 6.0 (Q1.7.24) on write.
module relu_result_collector
    import kws_act_pkg::*;
#(
    parameter int DEPTH  = ACT_DEPTH,
    parameter int ADDR_W = ACT_ADDR_W,
    parameter int DATA_W = ACT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        frame_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              dup_err,
    output logic              oor_err,
    input  logic              clear_err
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

    act_state_t        r_state, w_state_next;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_ptr;
    logic [DEPTH-1:0]  r_bitmap;
    logic              r_frame_done;
    logic              r_dup_err;
    logic              r_oor_err;

    logic              w_collect, w_drain, w_start_acc;
    logic              w_in_range, w_wr_en, w_wr_new, w_dup, w_oor;
    logic              w_xfer, w_last;
    logic [ADDR_W:0]   w_len_eff;
    logic [ADDR_W:0]   w_count_inc;
    logic [DEPTH-1:0]  w_addr_onehot;
    logic [DATA_W-1:0] w_wr_data;
    logic [DATA_W-1:0] w_mem_rd;

    assign w_collect   = (r_state == COLLECT);
    assign w_drain     = (r_state == DRAIN);
    assign w_start_acc = (r_state == IDLE) && start;
    assign w_len_eff   = (frame_len == 6'd0 || frame_len > 6'(DEPTH)) ? LEN_MAX
                                                                      : frame_len[ADDR_W:0];

    assign w_in_range  = ({1'b0, in_addr} < r_len);
    assign w_wr_en     = w_collect && in_valid && w_in_range;
    assign w_dup       = w_wr_en && r_bitmap[in_addr];
    assign w_wr_new    = w_wr_en && !r_bitmap[in_addr];
    assign w_oor       = in_valid && !(w_collect && w_in_range);
    assign w_count_inc = r_count + 1'b1;

    assign w_last      = w_drain && ({1'b0, r_ptr} == r_len - 1'b1);
    assign w_xfer      = w_drain && rd_ready;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_onehot
            assign w_addr_onehot[gi] = (in_addr == ADDR_W'(gi));
        end
    endgenerate

`ifdef RELU6_CLIP_EN
    assign w_wr_data = ($signed(in_data) > $signed(RELU6_MAX)) ? DATA_W'(RELU6_MAX) : in_data;
`else
    assign w_wr_data = in_data;
`endif

    act_regfile #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (in_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (r_ptr),
        .o_rd_data (w_mem_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = COLLECT;
            COLLECT: if (w_wr_new && w_count_inc == r_len) w_state_next = DRAIN;
            DRAIN:   if (w_xfer && w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len        <= '0;
            r_count      <= '0;
            r_ptr        <= '0;
            r_bitmap     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_collect && (w_state_next == DRAIN);
            if (w_start_acc) begin
                r_len    <= w_len_eff;
                r_count  <= '0;
                r_bitmap <= '0;
            end else if (w_wr_new) begin
                r_count  <= w_count_inc;
                r_bitmap <= r_bitmap | w_addr_onehot;
            end
            if (w_xfer) begin
                r_ptr <= w_last ? '0 : r_ptr + 1'b1;
            end
        end
    end

    // clear_err wins over a same-cycle violation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dup_err <= 1'b0;
            r_oor_err <= 1'b0;
        end else if (clear_err) begin
            r_dup_err <= 1'b0;
            r_oor_err <= 1'b0;
        end else begin
            if (w_dup) r_dup_err <= 1'b1;
            if (w_oor) r_oor_err <= 1'b1;
        end
    end

    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign rd_valid   = w_drain;
    assign rd_addr    = w_drain ? r_ptr : '0;
    assign rd_data    = w_drain ? w_mem_rd : '0;
    assign rd_last    = w_last;
    assign dup_err    = r_dup_err;
    assign oor_err    = r_oor_err;

endmodule

// File: tb/tb_relu_result_collector.sv
// Directed self-checking bench for relu_result_collector.
module tb_relu_result_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  frame_len;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_addr;
    logic        busy, frame_done, rd_valid, rd_ready, rd_last, dup_err, oor_err, clear_err;
    logic [31:0] rd_data;
    logic [4:0]  rd_addr;

    int n_pass  = 0;
    int n_total = 0;

    relu_result_collector dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_len  (frame_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .busy       (busy),
        .frame_done (frame_done),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_addr    (rd_addr),
        .rd_last    (rd_last),
        .dup_err    (dup_err),
        .oor_err    (oor_err),
        .clear_err  (clear_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [5:0] len);
        start = 1'b1;
        frame_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr = a;
        in_data = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({busy, frame_done, rd_valid, rd_last, dup_err, oor_err} !== 6'b0 ||
            rd_data !== 32'h0 || rd_addr !== 5'h0) begin
            $display("FAIL reset_outputs: got busy=%b fd=%b rv=%b rl=%b dup=%b oor=%b data=%h addr=%h, want all 0",
                     busy, frame_done, rd_valid, rd_last, dup_err, oor_err, rd_data, rd_addr);
        end else n_pass++;
    endtask

    task automatic test_full_frame();
        logic [4:0] a;
        do_start(6'd0);
        n_total++;
        if (busy !== 1'b1) $display("FAIL full_busy: got %b want 1", busy);
        else n_pass++;
        for (int i = 31; i >= 0; i--) begin
            a = 5'(i);
            do_write(a, {3'b000, a, 24'h0});
            if (i == 1) begin
                n_total++;
                if (frame_done !== 1'b0) $display("FAIL full_early_done: got %b want 0", frame_done);
                else n_pass++;
            end
        end
        n_total++;
        if (frame_done !== 1'b1 || rd_valid !== 1'b1)
            $display("FAIL full_done: got fd=%b rv=%b want 1 1", frame_done, rd_valid);
        else n_pass++;
        rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a = 5'(i);
            n_total++;
            if (rd_valid !== 1'b1 || rd_addr !== a || rd_data !== {3'b000, a, 24'h0} ||
                rd_last !== (i == 31))
                $display("FAIL full_beat%0d: got rv=%b addr=%h data=%h last=%b want 1 %h %h %b",
                         i, rd_valid, rd_addr, rd_data, rd_last, a, {3'b000, a, 24'h0}, (i == 31));
            else n_pass++;
            if (i == 1) begin
                n_total++;
                if (frame_done !== 1'b0) $display("FAIL full_done_pulse: got %b want 0", frame_done);
                else n_pass++;
            end
            tick();
        end
        rd_ready = 1'b0;
        n_total++;
        if (busy !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL full_idle: got busy=%b rv=%b want 0 0", busy, rd_valid);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [4:0] order [4];
        int exp_ptr;
        int xfers;
        order[0] = 5'd2; order[1] = 5'd0; order[2] = 5'd3; order[3] = 5'd1;
        do_start(6'd4);
        for (int i = 0; i < 4; i++) do_write(order[i], 32'hA0 + 32'(order[i]));
        exp_ptr = 0;
        xfers = 0;
        for (int c = 0; c < 20 && exp_ptr < 4; c++) begin
            n_total++;
            if (rd_valid !== 1'b1 || rd_addr !== 5'(exp_ptr) || rd_data !== 32'hA0 + 32'(exp_ptr) ||
                rd_last !== (exp_ptr == 3))
                $display("FAIL bp_cycle%0d: got rv=%b addr=%h data=%h last=%b want 1 %h %h %b",
                         c, rd_valid, rd_addr, rd_data, rd_last, 5'(exp_ptr), 32'hA0 + 32'(exp_ptr),
                         (exp_ptr == 3));
            else n_pass++;
            rd_ready = (c % 2 == 0);
            tick();
            if (rd_ready) begin
                exp_ptr++;
                xfers++;
            end
        end
        rd_ready = 1'b0;
        n_total++;
        if (xfers !== 4 || busy !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL bp_end: got xfers=%0d busy=%b rv=%b want 4 0 0", xfers, busy, rd_valid);
        else n_pass++;
    endtask

    task automatic test_duplicate();
        do_start(6'd2);
        do_write(5'd0, 32'h1);
        n_total++;
        if (dup_err !== 1'b0) $display("FAIL dup_first: got %b want 0", dup_err);
        else n_pass++;
        do_write(5'd0, 32'h2);
        n_total++;
        if (dup_err !== 1'b1 || frame_done !== 1'b0 || busy !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL dup_second: got dup=%b fd=%b busy=%b rv=%b want 1 0 1 0",
                     dup_err, frame_done, busy, rd_valid);
        else n_pass++;
        do_write(5'd1, 32'h3);
        n_total++;
        if (frame_done !== 1'b1) $display("FAIL dup_done: got %b want 1", frame_done);
        else n_pass++;
        rd_ready = 1'b1;
        n_total++;
        if (rd_data !== 32'h2 || rd_last !== 1'b0)
            $display("FAIL dup_beat0: got data=%h last=%b want 00000002 0", rd_data, rd_last);
        else n_pass++;
        tick();
        n_total++;
        if (rd_data !== 32'h3 || rd_last !== 1'b1)
            $display("FAIL dup_beat1: got data=%h last=%b want 00000003 1", rd_data, rd_last);
        else n_pass++;
        tick();
        rd_ready = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_total++;
        if (dup_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL dup_clear: got dup=%b busy=%b want 0 0", dup_err, busy);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        do_start(6'd3);
        do_write(5'd5, 32'hDEAD);
        n_total++;
        if (oor_err !== 1'b1 || busy !== 1'b1 || dup_err !== 1'b0)
            $display("FAIL oor_addr: got oor=%b busy=%b dup=%b want 1 1 0", oor_err, busy, dup_err);
        else n_pass++;
        do_write(5'd0, 32'h10);
        do_write(5'd1, 32'h11);
        n_total++;
        if (frame_done !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL oor_count: got fd=%b rv=%b want 0 0", frame_done, rd_valid);
        else n_pass++;
        do_write(5'd2, 32'h12);
        n_total++;
        if (frame_done !== 1'b1) $display("FAIL oor_done: got %b want 1", frame_done);
        else n_pass++;
        rd_ready = 1'b1;
        tick(); tick(); tick();
        rd_ready = 1'b0;
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_total++;
        if (oor_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL oor_clear: got oor=%b busy=%b want 0 0", oor_err, busy);
        else n_pass++;
        do_write(5'd0, 32'h99);
        n_total++;
        if (oor_err !== 1'b1 || busy !== 1'b0)
            $display("FAIL oor_idle_write: got oor=%b busy=%b want 1 0", oor_err, busy);
        else n_pass++;
        clear_err = 1'b1;
        do_write(5'd0, 32'h99);
        clear_err = 1'b0;
        n_total++;
        if (oor_err !== 1'b0) $display("FAIL oor_clear_priority: got %b want 0", oor_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        do_start(6'd8);
        for (int i = 0; i < 8; i++) do_write(5'(i), 32'h40 + 32'(i));
        rd_ready = 1'b1;
        tick(); tick();
        rd_ready = 1'b0;
        n_total++;
        if (rd_addr !== 5'd2 || rd_data !== 32'h42)
            $display("FAIL rst_pre: got addr=%h data=%h want 02 00000042", rd_addr, rd_data);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({busy, frame_done, rd_valid, rd_last, dup_err, oor_err} !== 6'b0 ||
            rd_data !== 32'h0 || rd_addr !== 5'h0)
            $display("FAIL rst_async: got busy=%b fd=%b rv=%b rl=%b data=%h addr=%h want all 0",
                     busy, frame_done, rd_valid, rd_last, rd_data, rd_addr);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        do_start(6'd1);
        tick(); tick();
        n_total++;
        if (busy !== 1'b1 || frame_done !== 1'b0 || rd_valid !== 1'b0)
            $display("FAIL rst_fresh_wait: got busy=%b fd=%b rv=%b want 1 0 0", busy, frame_done, rd_valid);
        else n_pass++;
        do_write(5'd0, 32'h55);
        n_total++;
        if (frame_done !== 1'b1 || rd_data !== 32'h55 || rd_last !== 1'b1)
            $display("FAIL rst_fresh_done: got fd=%b data=%h last=%b want 1 00000055 1",
                     frame_done, rd_data, rd_last);
        else n_pass++;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        n_total++;
        if (busy !== 1'b0) $display("FAIL rst_fresh_idle: got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_clip_back_to_back();
        logic [31:0] exp0;
`ifdef RELU6_CLIP_EN
        exp0 = 32'h0600_0000;
`else
        exp0 = 32'h0780_0000;
`endif
        do_start(6'd2);
        do_write(5'd0, 32'h0780_0000);
        do_write(5'd1, 32'h0500_0000);
        rd_ready = 1'b1;
        n_total++;
        if (rd_data !== exp0) $display("FAIL clip_beat0: got %h want %h", rd_data, exp0);
        else n_pass++;
        tick();
        n_total++;
        if (rd_data !== 32'h0500_0000 || rd_last !== 1'b1)
            $display("FAIL clip_beat1: got data=%h last=%b want 05000000 1", rd_data, rd_last);
        else n_pass++;
        tick();
        rd_ready = 1'b0;
        do_start(6'd1);
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_start: got busy=%b want 1", busy);
        else n_pass++;
        do_write(5'd0, 32'hFF00_0000);
        n_total++;
        if (frame_done !== 1'b1 || rd_data !== 32'hFF00_0000)
            $display("FAIL b2b_neg: got fd=%b data=%h want 1 ff000000", frame_done, rd_data);
        else n_pass++;
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        frame_len = 6'd0;
        in_valid = 1'b0;
        in_data = 32'h0;
        in_addr = 5'h0;
        rd_ready = 1'b0;
        clear_err = 1'b0;
        tick(); tick();
        test_reset();
        rst = 1'b0;
        tick();
        test_reset();
        test_full_frame();
        test_backpressure();
        test_duplicate();
        test_out_of_range();
        test_reset_mid_drain();
        test_clip_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/relu_result_collector.md
# relu_result_collector

Receiving end of the ReLU output stream. Captures the `output_valid`/`output_data`/`output_addr` beats that the ReLU stage produces into a 32-entry activation register file, and tracks which addresses have been written. Once a configured frame length has been filled, it streams the frame out in address order on a valid/ready port to the next layer.

## Interface
Parameters:
- `DEPTH`, 32: entries in the activation store.
- `ADDR_W`, 5: address width; equals clog2(`DEPTH`).
- `DATA_W`, 32: activation width, Q1.7.24 signed.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: arms a new frame; honoured only in IDLE.
- `frame_len` in 6: entries expected, sampled on `start`; 0 is treated as 32; values >32 are clamped to 32.
- `in_valid` in 1: write beat; connects to ReLU `output_valid`.
- `in_data` in 32: connects to ReLU `output_data`.
- `in_addr` in 5: connects to ReLU `output_addr`.
- `busy` out 1: high in COLLECT and DRAIN.
- `frame_done` out 1: one-cycle pulse when the frame is complete.
- `rd_valid` out 1: drain data valid.
- `rd_ready` in 1: downstream accept.
- `rd_data` out 32: activation at `rd_addr`.
- `rd_addr` out 5: drain pointer.
- `rd_last` out 1: high with the final drain beat.
- `dup_err` out 1: sticky; an already-written address was rewritten.
- `oor_err` out 1: sticky; address ≥ length, or a write arrived outside COLLECT.
- `clear_err` in 1: clears both error flags.

## Operation
- State IDLE:
  - `in_valid` is ignored, and sets `oor_err` if asserted.
  - `start` latches the length, clears the written-bitmap and count, and moves to COLLECT.
- State COLLECT, on `in_valid`:
  - If `in_addr` ≥ len: no write, set `oor_err`.
  - Else if bitmap[`in_addr`] is set: overwrite `mem[in_addr]`, set `dup_err`, count unchanged (last write wins).
  - Else: write, set bit, count += 1.
  - When count reaches len, go to DRAIN.
- State DRAIN:
  - `rd_valid`=1, `rd_addr`=ptr, `rd_data`=mem[ptr] (combinational read), `rd_last`=(ptr==len-1).
  - Transfer occurs on `rd_valid` & `rd_ready`: ptr += 1.
  - The transfer with `rd_last` returns the block to IDLE and ptr to 0.
  - `in_valid` here is ignored and sets `oor_err`.
- `start` outside IDLE is ignored; no error.
- `clear_err` takes priority over a setting event in the same cycle.
- `rd_valid`, once high, stays high with stable `rd_data`/`rd_addr` until the transfer.

## Timing
- Reset values: state IDLE, ptr 0, count 0, bitmap 0. All outputs are 0 (`busy`, `frame_done`, `rd_valid`, `rd_data`, `rd_addr`, `rd_last`, `dup_err`, `oor_err`).
- Memory contents are not reset.
- `start` at edge k gives `busy`=1 after k; an `in_valid` in the cycle after k is captured.
- Final unique write at edge k: state DRAIN after k, with `frame_done`=1 and `rd_valid`=1 in that same cycle. `frame_done` drops after one cycle.
- No write-to-read bypass is needed, since the final write lands before the first read.
- Drain throughput is one entry per cycle with `rd_ready` held high. `busy` falls the cycle after the last transfer.
- Reset mid-COLLECT or mid-DRAIN aborts the frame. The bitmap clears, so stale memory is never presented as valid.
- `start` in the cycle after the last drain transfer is accepted, giving back-to-back frames.

## Configuration
- `RELU6_CLIP_EN` defined:
  - Data is clipped on write: if `$signed(in_data)` > 0x06000000 (6.0 in Q1.7.24), the stored value is 0x06000000.
  - Negative values are stored unchanged.
- Undefined: data is stored verbatim.
- The macro has no effect on the bitmap, errors or timing.

## Structure
- Package `kws_act_pkg` holds:
  - the state enum IDLE/COLLECT/DRAIN;
  - the `DEPTH`, `ADDR_W` and `DATA_W` constants;
  - `RELU6_MAX` = 32'h0600_0000.
- Sub-module `act_regfile`: `DEPTH` x `DATA_W`, one synchronous write port and one asynchronous read port, no reset. Instantiated once.
- Collector FSM, bitmap, counters and error flags live in the top module.

## Test plan
- Full frame: `start`, len=0; write addr 31..0 with data=addr<<24.
  - `frame_done` appears 1 cycle after the last write.
  - Drain with `rd_ready`=1 gives 32 beats with `rd_data`=0x00000000..0x1F000000 and `rd_last` on addr 31.
- Short frame with backpressure: len=4, writes to 2,0,3,1, `rd_ready` toggling 1/0.
  - Exactly 4 transfers occur, in addr 0-3 order.
  - Data is stable while stalled; `rd_last` is on addr 3; IDLE follows.
- Duplicate: len=2, write addr0=0x1, addr0=0x2, addr1=0x3.
  - `dup_err`=1; `frame_done` only after addr1.
  - Drain gives 0x2, 0x3.
- Out of range / outside COLLECT: len=3, write addr 5; write in IDLE.
  - `oor_err`=1 and count unchanged.
  - `clear_err` in the same cycle as a new violation leaves the flag 0.
- Reset mid-drain: `rst` pulsed after 2 of 8 beats.
  - All outputs 0 and `busy`=0.
  - A new `start` with len=1 needs a fresh write before `frame_done`.
- `RELU6_CLIP_EN`: write 0x07800000 and 0x05000000.
  - Drain gives 0x06000000, 0x05000000.
  - With the macro undefined: 0x07800000, 0x05000000.
